ndma_reg_mc: RTL and testbench
==============================

# ndma_reg_mc

Multi-channel register file and control front-end for the NanoDMA engine. It is an OBI subordinate that holds per-channel source address, destination address, length and control. It issues a one-cycle start pulse per channel, tracks each channel's busy/done state from engine completion pulses, and raises per-channel interrupts. It sits between the system interconnect and the DMA channel arbiter/engine.

## Interface
Parameters:
- NumCh, 4, number of DMA channels (1..16).
- LenWidth, 8, transfer-length field width in bits (1..24).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  OBI request.
- we_i  in  1  OBI write enable (1 = write).
- gnt_o  out  1  OBI grant.
- addr_i  in  32  OBI byte address.
- wdata_i  in  32  OBI write data.
- rdata_o  out  32  OBI read data, valid with rvalid_o.
- rvalid_o  out  1  OBI response valid.
- err_o  out  1  OBI response error, valid with rvalid_o.
- ch_start_o  out  NumCh  one-cycle start pulse per channel.
- ch_src_addr_o  out  NumCh x 32  per-channel source address.
- ch_dst_addr_o  out  NumCh x 32  per-channel destination address.
- ch_len_o  out  NumCh x LenWidth  per-channel transfer length.
- ch_done_i  in  NumCh  one-cycle completion pulse from the engine.
- irq_o  out  NumCh  per-channel interrupt, level.

## Operation
- Decode: ChW = max(1, clog2(NumCh)).
  - Channel index = addr_i[4+ChW-1:4].
  - Register = addr_i[3:2].
  - Other address bits are ignored.
- Per-channel registers:
  - 0x0 CFG: [31] start (write-only, reads 0); [30] irq_en; [LenWidth-1:0] len. Other bits read 0.
  - 0x4 SRC: 32-bit source address.
  - 0x8 DST: 32-bit destination address.
  - 0xC STATUS: [0] busy (read-only); [1] done (write 1 to clear). Other bits read 0.
- Channel index >= NumCh: no state change; read data 0; err_o=1.
- CFG write to a busy channel: the whole write is ignored and err_o=1. SRC/DST writes while busy are also ignored with err_o=1.
- CFG write with wdata_i[31]=1 to an idle channel, all in one edge:
  - len and irq_en are written.
  - ch_start_o[ch] pulses for the next cycle.
  - busy is set.
  - done is cleared.
- CFG write with bit 31=0 only updates len and irq_en.
- Per-channel state machine:
  - IDLE -> BUSY on accepted start.
  - BUSY -> IDLE on ch_done_i[ch], which also sets done.
  - ch_done_i on an idle channel is ignored.
- Same-cycle done set and STATUS W1C on one channel: the set wins, so done=1.
- Same-cycle ch_done_i and a CFG start write on that channel: the channel is busy at decode, so the write is rejected (err_o=1); the channel goes IDLE with done=1.
- irq_o[ch] = done[ch] & irq_en[ch], driven from registers.
- ch_src_addr_o, ch_dst_addr_o and ch_len_o are driven directly from registers.

## Timing
- gnt_o = req_i combinationally; every request is accepted in its own cycle, back-to-back allowed.
- Response (writes and reads): rvalid_o=1 exactly one cycle after each grant, carrying rdata_o and err_o from registers. rdata_o=0 and err_o=0 whenever rvalid_o=0.
- Write effect is visible at the grant edge, so a read issued the next cycle returns the new value.
- Start latency: ch_start_o high in the cycle after the CFG write grant, for exactly 1 cycle. busy reads 1 from that same cycle.
- Done latency: done/irq_o asserted in the cycle after ch_done_i.
- Reset values, all zero: every register, rvalid_o, err_o, rdata_o, ch_start_o, irq_o and all channel outputs.
- Reset mid-transfer clears busy/done immediately; a later ch_done_i for the aborted transfer is ignored.

## Test plan
- Reset check: assert rst_i mid-operation -> all outputs 0; a read of 0x0/0x4/0x8/0xC of every channel returns 0.
- Programming and start:
  - Write ch2 SRC=0x1000_0000, DST=0x2000_0000, then CFG=0xC000_0010.
  - -> ch_start_o=0b0100 for 1 cycle; ch_len_o[2]=0x10; STATUS ch2 reads 0x1.
- Completion and clear:
  - Pulse ch_done_i[2] -> next cycle STATUS ch2 = 0x2 and irq_o[2]=1.
  - Write STATUS=0x2 -> irq_o[2]=0.
- Busy protection: while ch1 is busy, write CFG=0x8000_0005 -> err_o=1 with rvalid_o, no ch_start_o, len unchanged.
- Address error: with NumCh=3, read channel 3 -> rvalid_o=1, err_o=1, rdata_o=0.
- Collisions:
  - Same cycle ch_done_i[0] and W1C on ch0 -> done stays 1.
  - Back-to-back requests every cycle -> one rvalid_o per grant, in order.

Source files
------------

// File: rtl/ndma_reg_mc.sv
// ndma_reg_mc - multi-channel register file and control front-end for NanoDMA.
//
// An OBI subordinate holding per-channel SRC/DST/CFG/STATUS registers. It
// issues a one-cycle start pulse per channel, tracks busy/done from engine
// completion pulses and raises level interrupts.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), async active-high reset
//   req_i, we_i, gnt_o        OBI request / write enable / grant
//   addr_i, wdata_i           OBI byte address / write data
//   rdata_o, rvalid_o, err_o  OBI response, one cycle after each grant
//   ch_start_o                one-cycle start pulse per channel
//   ch_src_addr_o             per-channel source address
//   ch_dst_addr_o             per-channel destination address
//   ch_len_o                  per-channel transfer length
//   ch_done_i                 one-cycle completion pulse from the engine
//   irq_o                     per-channel level interrupt (done & irq_en)
module ndma_reg_mc #(
  parameter int NumCh    = 4,
  parameter int LenWidth = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               req_i,
  input  logic                               we_i,
  output logic                               gnt_o,
  input  logic [31:0]                        addr_i,
  input  logic [31:0]                        wdata_i,
  output logic [31:0]                        rdata_o,
  output logic                               rvalid_o,
  output logic                               err_o,
  output logic [NumCh-1:0]                   ch_start_o,
  output logic [NumCh-1:0][31:0]             ch_src_addr_o,
  output logic [NumCh-1:0][31:0]             ch_dst_addr_o,
  output logic [NumCh-1:0][LenWidth-1:0]     ch_len_o,
  input  logic [NumCh-1:0]                   ch_done_i,
  output logic [NumCh-1:0]                   irq_o
);

  localparam int ChW = (NumCh > 1) ? $clog2(NumCh) : 1;

  localparam logic [1:0] REG_CFG    = 2'd0;
  localparam logic [1:0] REG_SRC    = 2'd1;
  localparam logic [1:0] REG_DST    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ch_state_e;

  ch_state_e                    state_r      [NumCh];
  ch_state_e                    state_next_s [NumCh];
  logic [NumCh-1:0][31:0]       src_r;
  logic [NumCh-1:0][31:0]       dst_r;
  logic [NumCh-1:0][LenWidth-1:0] len_r;
  logic [NumCh-1:0]             irq_en_r;
  logic [NumCh-1:0]             done_r;
  logic [NumCh-1:0]             start_r;
  logic [NumCh-1:0]             done_next_s;
  logic [NumCh-1:0]             start_next_s;
  logic [NumCh-1:0]             hit_s;

  logic [ChW-1:0]               ch_idx_s;
  logic [31:0]                  ch_num_s;
  logic [1:0]                   reg_sel_s;
  logic                         ch_ok_s;
  logic                         sel_busy_s;
  logic                         wr_blocked_s;
  logic                         wr_ok_s;
  logic                         err_next_s;
  logic [31:0]                  rd_mux_s;
  logic [31:0]                  rdata_next_s;

  logic                         rvalid_r;
  logic                         err_r;
  logic [31:0]                  rdata_r;

  logic                         unused_addr_s;

  assign gnt_o     = req_i;
  assign ch_idx_s  = addr_i[4 +: ChW];
  assign ch_num_s  = {{(32-ChW){1'b0}}, ch_idx_s};
  assign reg_sel_s = addr_i[3:2];
  assign ch_ok_s   = (ch_num_s < NumCh);

  // Address bits outside the channel/register fields carry no meaning.
  assign unused_addr_s = ^{addr_i[31:4+ChW], addr_i[1:0]};

  // Address decode: channel hit vector, selected channel busy flag, read mux.
  always_comb begin
    hit_s      = '0;
    sel_busy_s = 1'b0;
    rd_mux_s   = 32'd0;
    for (int i = 0; i < NumCh; i++) begin
      if (ch_ok_s && (ch_num_s == i)) begin
        hit_s[i]   = req_i;
        sel_busy_s = (state_r[i] == ST_BUSY);
        case (reg_sel_s)
          REG_CFG: begin
            rd_mux_s[30]           = irq_en_r[i];
            rd_mux_s[LenWidth-1:0] = len_r[i];
          end
          REG_SRC:    rd_mux_s = src_r[i];
          REG_DST:    rd_mux_s = dst_r[i];
          REG_STATUS: rd_mux_s[1:0] = {done_r[i], (state_r[i] == ST_BUSY)};
          default:    rd_mux_s = 32'd0;
        endcase
      end else begin
        hit_s[i] = 1'b0;
      end
    end
  end

  // A busy channel only accepts STATUS writes; the decode sees pre-edge state,
  // so a same-cycle completion does not unblock a colliding CFG write.
  assign wr_blocked_s = we_i & sel_busy_s & (reg_sel_s != REG_STATUS);
  assign wr_ok_s      = we_i & ~wr_blocked_s;
  assign err_next_s   = req_i & (~ch_ok_s | wr_blocked_s);
  assign rdata_next_s = (req_i && !we_i && ch_ok_s) ? rd_mux_s : 32'd0;

  // Per-channel FSM next state, start pulse and done flag (done set wins over W1C).
  always_comb begin
    for (int i = 0; i < NumCh; i++) begin
      state_next_s[i] = state_r[i];
      start_next_s[i] = 1'b0;
      done_next_s[i]  = done_r[i];
      case (state_r[i])
        ST_IDLE: begin
          if (hit_s[i] && wr_ok_s && (reg_sel_s == REG_CFG) && wdata_i[31]) begin
            state_next_s[i] = ST_BUSY;
            start_next_s[i] = 1'b1;
            done_next_s[i]  = 1'b0;
          end else if (hit_s[i] && wr_ok_s && (reg_sel_s == REG_STATUS) && wdata_i[1]) begin
            done_next_s[i] = 1'b0;
          end else begin
            done_next_s[i] = done_r[i];
          end
        end
        ST_BUSY: begin
          if (ch_done_i[i]) begin
            state_next_s[i] = ST_IDLE;
            done_next_s[i]  = 1'b1;
          end else if (hit_s[i] && wr_ok_s && (reg_sel_s == REG_STATUS) && wdata_i[1]) begin
            done_next_s[i] = 1'b0;
          end else begin
            done_next_s[i] = done_r[i];
          end
        end
        default: begin
          state_next_s[i] = ST_IDLE;
          done_next_s[i]  = 1'b0;
        end
      endcase
    end
  end

  // Channel state registers and configuration register writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCh; i++) begin
        state_r[i] <= ST_IDLE;
      end
      src_r    <= '0;
      dst_r    <= '0;
      len_r    <= '0;
      irq_en_r <= '0;
      done_r   <= '0;
      start_r  <= '0;
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        state_r[i] <= state_next_s[i];
        if (hit_s[i] && wr_ok_s) begin
          case (reg_sel_s)
            REG_CFG: begin
              len_r[i]    <= wdata_i[LenWidth-1:0];
              irq_en_r[i] <= wdata_i[30];
            end
            REG_SRC: src_r[i] <= wdata_i;
            REG_DST: dst_r[i] <= wdata_i;
            default: ;
          endcase
        end
      end
      done_r  <= done_next_s;
      start_r <= start_next_s;
    end
  end

  // OBI response pipeline: one registered response per grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'd0;
    end else begin
      rvalid_r <= req_i;
      err_r    <= err_next_s;
      rdata_r  <= rdata_next_s;
    end
  end

  assign rvalid_o      = rvalid_r;
  assign err_o         = err_r;
  assign rdata_o       = rdata_r;
  assign ch_start_o    = start_r;
  assign ch_src_addr_o = src_r;
  assign ch_dst_addr_o = dst_r;
  assign ch_len_o      = len_r;
  assign irq_o         = done_r & irq_en_r;

endmodule

// File: tb/tb_ndma_reg_mc.sv
// tb_ndma_reg_mc - scoreboard bench for ndma_reg_mc (3 channels, 8-bit length).
//
// Stimulus pushes the expected OBI response into a queue; a monitor pops and
// compares on every rvalid. Channel-side outputs are checked directly.
module tb_ndma_reg_mc;

  localparam int NCH = 3;
  localparam int LW  = 8;

  logic                     clk;
  logic                     rst;
  logic                     req;
  logic                     we;
  logic                     gnt;
  logic [31:0]              addr;
  logic [31:0]              wdata;
  logic [31:0]              rdata;
  logic                     rvalid;
  logic                     err;
  logic [NCH-1:0]           ch_start;
  logic [NCH-1:0][31:0]     src_o;
  logic [NCH-1:0][31:0]     dst_o;
  logic [NCH-1:0][LW-1:0]   len_o;
  logic [NCH-1:0]           ch_done;
  logic [NCH-1:0]           irq;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  ndma_reg_mc #(.NumCh(NCH), .LenWidth(LW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .we_i          (we),
    .gnt_o         (gnt),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .rdata_o       (rdata),
    .rvalid_o      (rvalid),
    .err_o         (err),
    .ch_start_o    (ch_start),
    .ch_src_addr_o (src_o),
    .ch_dst_addr_o (dst_o),
    .ch_len_o      (len_o),
    .ch_done_i     (ch_done),
    .irq_o         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: in-order compare against the scoreboard queue.
  always @(negedge clk) begin
    if (rvalid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got rvalid 1 with no outstanding request");
      end else begin
        mon_e = sb_q.pop_front();
        chk({mon_e.name, "_rdata"}, rdata, mon_e.rdata);
        chk({mon_e.name, "_err"}, {31'd0, err}, {31'd0, mon_e.err});
      end
    end else begin
      chk("idle_rdata", rdata, 32'd0);
      chk("idle_err", {31'd0, err}, 32'd0);
    end
  end

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] er, input logic ee, input logic [NCH-1:0] dn,
                     input string nm);
    @(negedge clk);
    req     = 1'b1;
    we      = w;
    addr    = a;
    wdata   = d;
    ch_done = dn;
    sb_q.push_back('{rdata: er, err: ee, name: nm});
  endtask

  task automatic idle();
    @(negedge clk);
    req     = 1'b0;
    we      = 1'b0;
    addr    = 32'd0;
    wdata   = 32'd0;
    ch_done = '0;
  endtask

  task automatic pulse_done(input logic [NCH-1:0] dn);
    idle();
    ch_done = dn;
    @(negedge clk);
    ch_done = '0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_start"}, {29'd0, ch_start}, 32'd0);
    chk({pfx, "_irq"}, {29'd0, irq}, 32'd0);
    chk({pfx, "_rvalid"}, {31'd0, rvalid}, 32'd0);
    chk({pfx, "_rdata"}, rdata, 32'd0);
    chk({pfx, "_err"}, {31'd0, err}, 32'd0);
    for (int i = 0; i < NCH; i++) begin
      chk({pfx, "_src"}, src_o[i], 32'd0);
      chk({pfx, "_dst"}, dst_o[i], 32'd0);
      chk({pfx, "_len"}, {24'd0, len_o[i]}, 32'd0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    req     = 1'b0;
    we      = 1'b0;
    addr    = 32'd0;
    wdata   = 32'd0;
    ch_done = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("por");
    @(negedge clk);
    rst = 1'b0;

    // Activity on ch0, then reset mid-transfer.
    bus(1'b1, 32'h04, 32'hAAAA_5555, 32'd0, 1'b0, 3'b000, "w_src0");
    bus(1'b1, 32'h00, 32'hC000_0007, 32'd0, 1'b0, 3'b000, "w_cfg0_start");
    idle();
    chk("pre_rst_start", {29'd0, ch_start}, 32'h1);
    chk("pre_rst_src0", src_o[0], 32'hAAAA_5555);
    chk("pre_rst_len0", {24'd0, len_o[0]}, 32'h7);
    idle();
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    pulse_done(3'b001);
    chk("aborted_done_irq", {29'd0, irq}, 32'd0);
    for (int c = 0; c < NCH; c++) begin
      for (int r = 0; r < 4; r++) begin
        bus(1'b0, 32'(c * 16 + r * 4), 32'd0, 32'd0, 1'b0, 3'b000, "rd_after_rst");
      end
    end

    // Program and start ch2.
    bus(1'b1, 32'h24, 32'h1000_0000, 32'd0, 1'b0, 3'b000, "w_src2");
    bus(1'b1, 32'h28, 32'h2000_0000, 32'd0, 1'b0, 3'b000, "w_dst2");
    bus(1'b1, 32'h20, 32'hC000_0010, 32'd0, 1'b0, 3'b000, "w_cfg2_start");
    bus(1'b0, 32'h2C, 32'd0, 32'h1, 1'b0, 3'b000, "st2_busy");
    chk("start_pulse_ch2", {29'd0, ch_start}, 32'h4);
    idle();
    chk("start_one_cycle", {29'd0, ch_start}, 32'd0);
    chk("len2", {24'd0, len_o[2]}, 32'h10);
    chk("src2", src_o[2], 32'h1000_0000);
    chk("dst2", dst_o[2], 32'h2000_0000);
    bus(1'b0, 32'h124, 32'd0, 32'h1000_0000, 1'b0, 3'b000, "rd_src2_alias");

    // Completion and W1C.
    pulse_done(3'b100);
    chk("irq2_set", {29'd0, irq}, 32'h4);
    bus(1'b0, 32'h2C, 32'd0, 32'h2, 1'b0, 3'b000, "st2_done");
    bus(1'b1, 32'h2C, 32'h2, 32'd0, 1'b0, 3'b000, "w1c2");
    idle();
    chk("irq2_clr", {29'd0, irq}, 32'd0);
    bus(1'b0, 32'h2C, 32'd0, 32'd0, 1'b0, 3'b000, "st2_cleared");

    // Busy protection on ch1.
    bus(1'b1, 32'h10, 32'h0000_0003, 32'd0, 1'b0, 3'b000, "cfg1_nostart");
    bus(1'b1, 32'h10, 32'h8000_0009, 32'd0, 1'b0, 3'b000, "cfg1_start");
    idle();
    chk("start_ch1", {29'd0, ch_start}, 32'h2);
    chk("len1", {24'd0, len_o[1]}, 32'h9);
    bus(1'b1, 32'h10, 32'h8000_0005, 32'd0, 1'b1, 3'b000, "cfg1_busy");
    idle();
    chk("busy_no_start", {29'd0, ch_start}, 32'd0);
    chk("busy_len1", {24'd0, len_o[1]}, 32'h9);
    bus(1'b1, 32'h14, 32'hDEAD_BEEF, 32'd0, 1'b1, 3'b000, "src1_busy");
    bus(1'b0, 32'h14, 32'd0, 32'd0, 1'b0, 3'b000, "rd_src1");
    bus(1'b0, 32'h10, 32'd0, 32'h9, 1'b0, 3'b000, "rd_cfg1");
    bus(1'b0, 32'h1C, 32'd0, 32'h1, 1'b0, 3'b000, "st1_busy");
    pulse_done(3'b010);
    chk("irq1_masked", {29'd0, irq}, 32'd0);
    bus(1'b0, 32'h1C, 32'd0, 32'h2, 1'b0, 3'b000, "st1_done");

    // Out-of-range channel.
    bus(1'b0, 32'h30, 32'd0, 32'd0, 1'b1, 3'b000, "rd_ch3");
    bus(1'b1, 32'h34, 32'h1234, 32'd0, 1'b1, 3'b000, "wr_ch3");
    bus(1'b1, 32'h30, 32'h8000_0001, 32'd0, 1'b1, 3'b000, "start_ch3");
    idle();
    chk("ch3_no_start", {29'd0, ch_start}, 32'd0);

    // Collisions on ch0.
    bus(1'b1, 32'h00, 32'hC000_0001, 32'd0, 1'b0, 3'b000, "cfg0_start");
    bus(1'b1, 32'h0C, 32'h2, 32'd0, 1'b0, 3'b001, "w1c0_vs_done");
    bus(1'b0, 32'h0C, 32'd0, 32'h2, 1'b0, 3'b000, "st0_set_wins");
    idle();
    chk("irq0_set", {29'd0, irq}, 32'h1);
    bus(1'b1, 32'h00, 32'hC000_0001, 32'd0, 1'b0, 3'b000, "cfg0_restart");
    bus(1'b1, 32'h00, 32'hC000_0002, 32'd0, 1'b1, 3'b001, "cfg0_vs_done");
    chk("irq0_restart_clr", {29'd0, irq}, 32'd0);
    bus(1'b0, 32'h0C, 32'd0, 32'h2, 1'b0, 3'b000, "st0_after_coll");
    chk("coll_no_start", {29'd0, ch_start}, 32'd0);
    idle();
    chk("coll_len0", {24'd0, len_o[0]}, 32'h1);
    chk("coll_irq0", {29'd0, irq}, 32'h1);

    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
    chk("drain_pending", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
